// File: rtl/chan_ram_bridge_pkg.sv
// Shared constants for the comm_fpga_fx2 channel bridge: channel map,
// ctrl register bit positions and the RAM read FSM encoding.
package chan_ram_bridge_pkg;

    localparam logic [6:0] CH_PTR_LO   = 7'd0;
    localparam logic [6:0] CH_PTR_HI   = 7'd1;
    localparam logic [6:0] CH_DATA     = 7'd2;
    localparam logic [6:0] CH_CTRL     = 7'd3;
    localparam logic [6:0] CH_DBG_BASE = 7'd8;

    localparam int CTRL_HALT    = 0;
    localparam int CTRL_CPU_RST = 1;
    localparam int CTRL_ERR     = 7;

    // Length of the cpu reset pulse requested through ctrl bit1.
    localparam logic [2:0] CPU_RST_CYCLES = 3'd4;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_WAIT,
        RD_READY
    } rd_state_t;

endpackage

// File: rtl/chan_rd_prefetch.sv
// RAM read sequencer for the data channel: presents ptr, waits out the RAM
// latency, offers the byte to the host and requests ptr++ on handshake.
//
// state    | meaning
// RD_IDLE  | no read in flight (not selected, not halted, or just aborted)
// RD_FETCH | ptr is on the RAM address bus
// RD_WAIT  | covering the remaining RD_LAT-1 cycles of RAM latency
// RD_READY | ram_dout is valid and offered to the host
module chan_rd_prefetch
    import chan_ram_bridge_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic abort,
    input  logic f2h_ready,
    output logic rd_valid,
    output logic ptr_inc
);

    rd_state_t  state;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RD_IDLE;
            wait_cnt <= '0;
            rd_valid <= 1'b0;
        end else if (abort || !enable) begin
            state    <= RD_IDLE;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: state <= RD_FETCH;
                RD_FETCH: begin
                    if (RD_LAT > 1) begin
                        wait_cnt <= 8'(RD_LAT - 2);
                        state    <= RD_WAIT;
                    end else begin
                        state    <= RD_READY;
                        rd_valid <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state    <= RD_READY;
                        rd_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                RD_READY: begin
                    if (f2h_ready) begin
                        state    <= RD_FETCH;
                        rd_valid <= 1'b0;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    assign ptr_inc = enable && !abort && (state == RD_READY) && f2h_ready;

endmodule

// File: rtl/chan_ram_bridge.sv
// Host channel bridge: halts the cpu, loads/reads RAM through an
// auto-incrementing pointer and exposes a cpu debug snapshot.
module chan_ram_bridge
    import chan_ram_bridge_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        chan_addr,
    input  logic [7:0]        h2f_data,
    input  logic              h2f_valid,
    output logic              h2f_ready,
    output logic [7:0]        f2h_data,
    output logic              f2h_valid,
    input  logic              f2h_ready,
    output logic              ram_sel,
    output logic [ADDR_W-1:0] br_ram_addr,
    output logic [7:0]        br_ram_din,
    output logic              br_ram_we,
    input  logic [7:0]        ram_dout,
    output logic              cpu_halt,
    output logic              cpu_rst_n,
    input  logic [7:0]        dbg_ir,
    input  logic [7:0]        dbg_state,
    input  logic [7:0]        dbg_pc,
    input  logic [7:0]        dbg_a,
    input  logic [7:0]        dbg_b,
    input  logic [7:0]        dbg_dat,
    input  logic [15:0]       dbg_mar,
    input  logic              dbg_zero,
    input  logic              dbg_sign
);

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       ptr16;
    logic [6:0]        chan_q;
    logic [2:0]        rst_cnt;
    logic [7:0]        f2h_mux;
    logic              live;
    logic              err;
    logic              xfer_w;
    logic              wr_ptr_lo;
    logic              wr_ptr_hi;
    logic              wr_data;
    logic              wr_ctrl;
    logic              abort;
    logic              rd_enable;
    logic              rd_valid;
    logic              ptr_inc;
    logic              rd_unhalted;

    assign ptr16       = 16'(ptr);
    assign xfer_w      = h2f_valid && h2f_ready;
    assign wr_ptr_lo   = xfer_w && (chan_addr == CH_PTR_LO);
    assign wr_ptr_hi   = xfer_w && (chan_addr == CH_PTR_HI);
    assign wr_data     = xfer_w && (chan_addr == CH_DATA);
    assign wr_ctrl     = xfer_w && (chan_addr == CH_CTRL);
    assign rd_unhalted = live && !cpu_halt && (chan_addr == CH_DATA) && f2h_ready;

    // Anything that could make the prefetched byte stale throws it away.
    assign abort = (chan_addr != chan_q) || wr_ptr_lo || wr_ptr_hi || wr_data ||
                   (wr_ctrl && !h2f_data[CTRL_HALT]);
    assign rd_enable = live && cpu_halt && (chan_addr == CH_DATA);

    assign ram_sel     = cpu_halt;
    assign br_ram_addr = br_ram_we ? wr_addr : ptr;

    chan_rd_prefetch #(
        .RD_LAT(RD_LAT)
    ) u_prefetch (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (rd_enable),
        .abort    (abort),
        .f2h_ready(f2h_ready),
        .rd_valid (rd_valid),
        .ptr_inc  (ptr_inc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live       <= 1'b0;
            h2f_ready  <= 1'b1;
            chan_q     <= '0;
            ptr        <= '0;
            wr_addr    <= '0;
            br_ram_din <= '0;
            br_ram_we  <= 1'b0;
            cpu_halt   <= 1'b1;
            cpu_rst_n  <= 1'b0;
            rst_cnt    <= CPU_RST_CYCLES - 3'd1;
            err        <= 1'b0;
        end else begin
            live      <= 1'b1;
            h2f_ready <= 1'b1;
            chan_q    <= chan_addr;

            if (wr_ptr_lo)
                ptr <= ADDR_W'({ptr16[15:8], h2f_data});
            else if (wr_ptr_hi)
                ptr <= ADDR_W'({h2f_data, ptr16[7:0]});
            else if ((wr_data && cpu_halt) || ptr_inc)
                ptr <= ptr + ADDR_W'(1);

            // Writes are staged one cycle so ptr can advance on the accept edge.
            br_ram_we <= wr_data && cpu_halt;
            if (wr_data && cpu_halt) begin
                wr_addr    <= ptr;
                br_ram_din <= h2f_data;
            end

            if (wr_ctrl)
                cpu_halt <= h2f_data[CTRL_HALT];

            if (wr_ctrl && h2f_data[CTRL_CPU_RST]) begin
                rst_cnt   <= CPU_RST_CYCLES - 3'd1;
                cpu_rst_n <= 1'b0;
            end else if (rst_cnt != 3'd0) begin
                rst_cnt <= rst_cnt - 3'd1;
            end else begin
                cpu_rst_n <= 1'b1;
            end

            if ((wr_data && !cpu_halt) || rd_unhalted)
                err <= 1'b1;
            else if (wr_ctrl && h2f_data[CTRL_ERR])
                err <= 1'b0;
        end
    end

    always_comb begin
        f2h_mux = 8'h00;
        case (chan_addr)
            CH_PTR_LO:           f2h_mux = ptr16[7:0];
            CH_PTR_HI:           f2h_mux = ptr16[15:8];
            CH_DATA:             f2h_mux = (cpu_halt && rd_valid) ? ram_dout : 8'h00;
            CH_CTRL:             f2h_mux = {err, 6'b0, cpu_halt};
            CH_DBG_BASE:         f2h_mux = dbg_ir;
            CH_DBG_BASE + 7'd1:  f2h_mux = dbg_state;
            CH_DBG_BASE + 7'd2:  f2h_mux = dbg_pc;
            CH_DBG_BASE + 7'd3:  f2h_mux = dbg_a;
            CH_DBG_BASE + 7'd4:  f2h_mux = dbg_b;
            CH_DBG_BASE + 7'd5:  f2h_mux = dbg_dat;
            CH_DBG_BASE + 7'd6:  f2h_mux = dbg_mar[7:0];
            CH_DBG_BASE + 7'd7:  f2h_mux = dbg_mar[15:8];
            CH_DBG_BASE + 7'd8:  f2h_mux = {6'b0, dbg_sign, dbg_zero};
            default:             f2h_mux = 8'h00;
        endcase
    end

    assign f2h_data  = live ? f2h_mux : 8'h00;
    assign f2h_valid = live && ((chan_addr != CH_DATA) || !cpu_halt || rd_valid);

endmodule
